// File: rtl/sar_ctrl_nonbinary_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_pkg
// Brief    : Shared types and constants for the multi-channel non-binary
//            SAR controller (state encoding, redundant weights, limits).
// Revision : 1.0 - initial release
// ============================================================================
package sar_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Redundant DAC weights, index 0 = LSB. Each weight is at most the sum of
    // all lower weights plus one, so a wrong early decision stays recoverable.
    localparam int MAX_STEPS = 12;
    localparam int WEIGHT [0:MAX_STEPS-1] = '{1, 2, 4, 8, 15, 28, 52, 96, 176, 324, 596, 1096};
    localparam int FULL_SCALE = 2398;

    // avg_mode codes above this value are treated as this value (R = 16).
    localparam logic [2:0] AVG_MODE_MAX = 3'd4;

    // Sum of the lowest n weights: the largest code a conversion can produce.
    function automatic int weight_sum(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) begin
            s += WEIGHT[i];
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_ctrl_nonbinary_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_nonbinary_seq_if
// Brief    : Result stream between the SAR controller and the digital side:
//            {channel, code} with valid/ready plus sticky overflow control.
// Revision : 1.0 - initial release
// ============================================================================
interface sar_ctrl_nonbinary_seq_if #(
    parameter int RESULT_BITS = 12,
    parameter int CH_W        = 2
);
    logic [RESULT_BITS-1:0] result_data;
    logic [CH_W-1:0]        result_ch;
    logic                   result_valid;
    logic                   result_ready;
    logic                   overflow;
    logic                   ovf_clear;

    modport master (
        output result_data, result_ch, result_valid, overflow,
        input  result_ready, ovf_clear
    );

    modport slave (
        input  result_data, result_ch, result_valid, overflow,
        output result_ready, ovf_clear
    );
endinterface
`default_nettype wire

// File: rtl/sar_ctrl_nonbinary_seq_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sar_result_fifo
// Brief    : 2-entry first-word-fall-through valid/ready buffer. A push into a
//            full buffer is dropped and raises a sticky overflow flag, unless
//            a pop in the same cycle frees a slot.
// Revision : 1.0 - initial release
// ============================================================================
module sar_result_fifo #(
    parameter int WIDTH = 14
) (
    input  wire logic             clk,
    input  wire logic             nrst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop_ready,
    input  wire logic             ovf_clear,
    output logic      [WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic                  overflow
);
    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [1:0]       r_cnt;
    logic             r_ovf;
    logic             w_pop;
    logic             w_push_ok;

    assign w_pop     = (r_cnt != 2'd0) && pop_ready;
    assign w_push_ok = push && ((r_cnt != 2'd2) || w_pop);

    // Storage and occupancy; r_d0 is always the head.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= 2'd0;
        end else if (w_push_ok && w_pop) begin
            if (r_cnt == 2'd2) begin
                r_d0 <= r_d1;
                r_d1 <= push_data;
            end else begin
                r_d0 <= push_data;
            end
        end else if (w_pop) begin
            r_d0  <= r_d1;
            r_cnt <= r_cnt - 2'd1;
        end else if (w_push_ok) begin
            if (r_cnt == 2'd0) begin
                r_d0 <= push_data;
            end else begin
                r_d1 <= push_data;
            end
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Sticky drop flag; a clear wins over a same-cycle drop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ovf <= 1'b0;
        end else if (ovf_clear) begin
            r_ovf <= 1'b0;
        end else if (push && !w_push_ok) begin
            r_ovf <= 1'b1;
        end
    end

    assign head_data  = r_d0;
    assign head_valid = (r_cnt != 2'd0);
    assign overflow   = r_ovf;
endmodule
`default_nettype wire

// File: rtl/sar_ctrl_nonbinary_seq.sv
`default_nettype none
// ============================================================================
// Module   : sar_ctrl_nonbinary_seq
// Brief    : Multi-channel non-binary SAR ADC controller. Round-robin channel
//            sequencing, redundant-weight accumulation, majority-vote averaging
//            of the trailing LSB steps, buffered {channel, result} output.
// Revision : 1.0 - initial release
// ============================================================================
module sar_ctrl_nonbinary_seq
    import sar_ctrl_pkg::*;
#(
    parameter int DAC_BITS      = 12,
    parameter int RESULT_BITS   = 12,
    parameter int NCH           = 4,
    parameter int CH_W          = 2,
    parameter int AVG_STEPS     = 4,
    parameter int SAMPLE_CYCLES = 2
) (
    input  wire logic                clk,
    input  wire logic                nrst,
    input  wire logic                start,
    input  wire logic                continuous,
    input  wire logic [NCH-1:0]      ch_mask,
    input  wire logic [2:0]          avg_mode,
    input  wire logic                comparator_in,
    output logic                     sample,
    output logic                     nsample,
    output logic                     enable,
    output logic [CH_W-1:0]          ch_sel,
    output logic [DAC_BITS-1:0]      p_switch,
    output logic [DAC_BITS-1:0]      n_switch,
    output logic                     busy,
    output logic                     conv_finished,
    sar_ctrl_nonbinary_seq_if.master res
);
    localparam logic [1:0] c_idle   = ST_IDLE;
    localparam logic [1:0] c_sample = ST_SAMPLE;
    localparam logic [1:0] c_conv   = ST_CONV;
    localparam logic [1:0] c_done   = ST_DONE;

    localparam int             c_k_w    = $clog2(DAC_BITS + 1);
    localparam logic [c_k_w-1:0] c_k_msb  = c_k_w'(DAC_BITS - 1);
    localparam logic [c_k_w-1:0] c_k_avg  = c_k_w'(AVG_STEPS);
    localparam int             c_s_w    = $clog2(SAMPLE_CYCLES + 1);
    localparam logic [c_s_w-1:0] c_s_last = c_s_w'(SAMPLE_CYCLES - 1);

    if ((DAC_BITS < 1) || (DAC_BITS > MAX_STEPS)) begin : g_chk_dac
        $error("DAC_BITS out of range of the weight table");
    end
    if ((AVG_STEPS < 0) || (AVG_STEPS > DAC_BITS)) begin : g_chk_avg
        $error("AVG_STEPS must not exceed DAC_BITS");
    end
    if ((SAMPLE_CYCLES < 1) || (NCH > (1 << CH_W))) begin : g_chk_misc
        $error("SAMPLE_CYCLES must be >= 1 and NCH must fit in CH_W bits");
    end
    if ((weight_sum(DAC_BITS) > ((1 << RESULT_BITS) - 1)) ||
        (weight_sum(MAX_STEPS) != FULL_SCALE)) begin : g_chk_scale
        $error("Weight sum does not fit RESULT_BITS");
    end

    logic [1:0]             r_state;
    logic [c_s_w-1:0]       r_scnt;
    logic [c_k_w-1:0]       r_k;
    logic [4:0]             r_rep;
    logic [4:0]             r_ones;
    logic [RESULT_BITS-1:0] r_acc;
    logic [DAC_BITS-1:0]    r_p;
    logic [DAC_BITS-1:0]    r_n;
    logic [CH_W-1:0]        r_ch;
    logic [NCH-1:0]         r_mask;
    logic [2:0]             r_avg;

    logic [2:0]             w_avg_clamped;
    logic [4:0]             w_len;
    logic [4:0]             w_ones_nx;
    logic                   w_dec;
    logic                   w_step_end;
    logic                   w_next_found;
    logic [CH_W-1:0]        w_next_ch;
    logic                   w_low_found;
    logic [CH_W-1:0]        w_low_ch;
    logic                   w_enter_sample;
    logic [CH_W-1:0]        w_enter_ch;
    logic                   w_relatch;

    // Step length and decision: averaged steps vote, ties resolve to 0.
    assign w_avg_clamped = (avg_mode > AVG_MODE_MAX) ? AVG_MODE_MAX : avg_mode;
    assign w_len         = (r_k < c_k_avg) ? (5'd1 << r_avg) : 5'd1;
    assign w_ones_nx     = r_ones + 5'(comparator_in);
    assign w_dec         = (r_k < c_k_avg) ? (w_ones_nx > (w_len >> 1)) : comparator_in;
    assign w_step_end    = (r_rep == (w_len - 5'd1));

    // Channel search: next set channel above the current one in the latched
    // mask, and the lowest set channel of the live mask for (re)starts.
    always_comb begin
        w_next_found = 1'b0;
        w_next_ch    = '0;
        w_low_found  = 1'b0;
        w_low_ch     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_mask[i] && (CH_W'(i) > r_ch)) begin
                w_next_found = 1'b1;
                w_next_ch    = CH_W'(i);
            end
            if (ch_mask[i]) begin
                w_low_found = 1'b1;
                w_low_ch    = CH_W'(i);
            end
        end
    end

    // Decide whether a new sample phase starts this cycle and on which channel.
    always_comb begin
        w_enter_sample = 1'b0;
        w_enter_ch     = r_ch;
        w_relatch      = 1'b0;
        if ((r_state == c_idle) && start && w_low_found) begin
            w_enter_sample = 1'b1;
            w_enter_ch     = w_low_ch;
            w_relatch      = 1'b1;
        end else if (r_state == c_done) begin
            if (w_next_found) begin
                w_enter_sample = 1'b1;
                w_enter_ch     = w_next_ch;
            end else if (continuous && w_low_found) begin
                w_enter_sample = 1'b1;
                w_enter_ch     = w_low_ch;
                w_relatch      = 1'b1;
            end
        end
    end

    // Main sequencer: sample timing, step walk, switch vectors, accumulator.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= c_idle;
            r_scnt  <= '0;
            r_k     <= '0;
            r_rep   <= '0;
            r_ones  <= '0;
            r_acc   <= '0;
            r_p     <= '0;
            r_n     <= '0;
            r_ch    <= '0;
            r_mask  <= '0;
            r_avg   <= '0;
        end else if (w_enter_sample) begin
            r_state <= c_sample;
            r_ch    <= w_enter_ch;
            r_scnt  <= '0;
            r_avg   <= w_avg_clamped;
            r_p     <= '0;
            r_n     <= '0;
            if (w_relatch) begin
                r_mask <= ch_mask;
            end
        end else begin
            case (r_state)
                c_sample: begin
                    if (r_scnt == c_s_last) begin
                        r_state <= c_conv;
                        r_k     <= c_k_msb;
                        r_rep   <= '0;
                        r_ones  <= '0;
                        r_acc   <= '0;
                    end else begin
                        r_scnt <= r_scnt + 1'b1;
                    end
                end
                c_conv: begin
                    if (w_step_end) begin
                        if (w_dec) begin
                            r_p[r_k] <= 1'b1;
                            r_acc    <= r_acc + RESULT_BITS'(WEIGHT[r_k]);
                        end else begin
                            r_n[r_k] <= 1'b1;
                        end
                        r_rep  <= '0;
                        r_ones <= '0;
                        if (r_k == '0) begin
                            r_state <= c_done;
                        end else begin
                            r_k <= r_k - 1'b1;
                        end
                    end else begin
                        r_rep  <= r_rep + 5'd1;
                        r_ones <= w_ones_nx;
                    end
                end
                c_done:  r_state <= c_idle;
                default: r_state <= c_idle;
            endcase
        end
    end

    sar_result_fifo #(
        .WIDTH (CH_W + RESULT_BITS)
    ) u_fifo (
        .clk        (clk),
        .nrst       (nrst),
        .push       (r_state == c_done),
        .push_data  ({r_ch, r_acc}),
        .pop_ready  (res.result_ready),
        .ovf_clear  (res.ovf_clear),
        .head_data  ({res.result_ch, res.result_data}),
        .head_valid (res.result_valid),
        .overflow   (res.overflow)
    );

    assign sample        = (r_state == c_sample);
    assign nsample       = ~sample;
    assign enable        = (r_state == c_conv);
    assign busy          = (r_state != c_idle);
    assign conv_finished = (r_state == c_done);
    assign ch_sel        = r_ch;
    assign p_switch      = r_p;
    assign n_switch      = r_n;
endmodule
`default_nettype wire

// File: tb/tb_sar_ctrl_nonbinary_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_ctrl_nonbinary_seq
// Brief    : Directed self-checking bench for sar_ctrl_nonbinary_seq with
//            hand-computed expected codes, latencies and buffer behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_ctrl_nonbinary_seq;
    logic        clk;
    logic        nrst;
    logic        start;
    logic        continuous;
    logic [3:0]  ch_mask;
    logic [2:0]  avg_mode;
    logic        comparator_in;
    logic        sample;
    logic        nsample;
    logic        enable;
    logic [1:0]  ch_sel;
    logic [11:0] p_switch;
    logic [11:0] n_switch;
    logic        busy;
    logic        conv_finished;

    int checks;
    int failures;
    int fin_cnt;
    logic        cmp_q [$];
    logic [13:0] got_q [$];

    sar_ctrl_nonbinary_seq_if #(.RESULT_BITS(12), .CH_W(2)) res_if ();

    sar_ctrl_nonbinary_seq dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .continuous    (continuous),
        .ch_mask       (ch_mask),
        .avg_mode      (avg_mode),
        .comparator_in (comparator_in),
        .sample        (sample),
        .nsample       (nsample),
        .enable        (enable),
        .ch_sel        (ch_sel),
        .p_switch      (p_switch),
        .n_switch      (n_switch),
        .busy          (busy),
        .conv_finished (conv_finished),
        .res           (res_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model: one scripted decision bit per conversion cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (enable) comparator_in = (cmp_q.size() > 0) ? cmp_q.pop_front() : 1'b0;
    end

    // Result consumer and conversion-pulse counter.
    initial forever begin
        @(negedge clk);
        if (nrst && res_if.result_valid && res_if.result_ready)
            got_q.push_back({res_if.result_ch, res_if.result_data});
        if (conv_finished) fin_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dec(input logic [11:0] d);
        for (int k = 11; k >= 0; k--) cmp_q.push_back(d[k]);
    endtask

    task automatic push_n(input int n, input logic v);
        for (int i = 0; i < n; i++) cmp_q.push_back(v);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (busy && t < 500) begin
            tick();
            t++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
        end
        tick();
        tick();
    endtask

    task automatic measure_latency(input int required, input string name);
        int n;
        do_start();
        n = 1;
        while (!conv_finished && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n !== required) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, n, required);
        end
    endtask

    task automatic prep(input logic [3:0] m, input logic [2:0] a, input logic c, input logic rdy);
        cmp_q.delete();
        got_q.delete();
        fin_cnt = 0;
        ch_mask = m;
        avg_mode = a;
        continuous = c;
        res_if.result_ready = rdy;
    endtask

    task automatic test_reset();
        checks++;
        if ({sample, nsample, enable, busy, conv_finished} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_ctrl: got s/ns/en/busy/fin=%b required 01000",
                     {sample, nsample, enable, busy, conv_finished});
        end
        checks++;
        if ({ch_sel, p_switch, n_switch} !== 26'd0) begin
            failures++;
            $display("FAIL reset_dac: got ch=%0d p=%h n=%h required 0", ch_sel, p_switch, n_switch);
        end
        checks++;
        if ({res_if.result_valid, res_if.overflow} !== 2'b00) begin
            failures++;
            $display("FAIL reset_buf: got valid/ovf=%b required 00",
                     {res_if.result_valid, res_if.overflow});
        end
    endtask

    task automatic test_single();
        logic [13:0] g0, g1;
        prep(4'b0101, 3'd0, 1'b0, 1'b1);
        push_dec(12'h800);
        push_dec(12'hFFF);
        do_start();
        wait_idle("single");
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        g1 = (got_q.size() > 1) ? got_q[1] : 14'h3FFF;
        checks++;
        if (fin_cnt !== 2 || got_q.size() !== 2) begin
            failures++;
            $display("FAIL single_count: got pulses=%0d results=%0d required 2/2", fin_cnt, got_q.size());
        end
        checks++;
        if (g0 !== {2'd0, 12'd1096}) begin
            failures++;
            $display("FAIL single_ch0: got ch=%0d res=%0d required ch=0 res=1096", g0[13:12], g0[11:0]);
        end
        checks++;
        if (g1 !== {2'd2, 12'd2398}) begin
            failures++;
            $display("FAIL single_ch2: got ch=%0d res=%0d required ch=2 res=2398", g1[13:12], g1[11:0]);
        end
        checks++;
        if (p_switch !== 12'hFFF || n_switch !== 12'h000) begin
            failures++;
            $display("FAIL single_switch: got p=%h n=%h required FFF/000", p_switch, n_switch);
        end
    endtask

    task automatic test_avg();
        logic [13:0] g0;
        prep(4'b0001, 3'd2, 1'b0, 1'b1);
        push_n(8, 1'b0);
        cmp_q.push_back(1'b1); cmp_q.push_back(1'b1); cmp_q.push_back(1'b0); cmp_q.push_back(1'b0);
        cmp_q.push_back(1'b1); cmp_q.push_back(1'b1); cmp_q.push_back(1'b1); cmp_q.push_back(1'b0);
        cmp_q.push_back(1'b0); cmp_q.push_back(1'b1); cmp_q.push_back(1'b1); cmp_q.push_back(1'b1);
        push_n(4, 1'b1);
        measure_latency(27, "avg4");
        wait_idle("avg4");
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        checks++;
        if (g0 !== {2'd0, 12'd7}) begin
            failures++;
            $display("FAIL avg4_result: got ch=%0d res=%0d required ch=0 res=7", g0[13:12], g0[11:0]);
        end
        checks++;
        if (p_switch !== 12'h007 || n_switch !== 12'hFF8) begin
            failures++;
            $display("FAIL avg4_switch: got p=%h n=%h required 007/FF8", p_switch, n_switch);
        end
    endtask

    task automatic test_avg_clamp();
        logic [13:0] g0;
        prep(4'b0001, 3'd7, 1'b0, 1'b1);
        push_n(8, 1'b0);
        push_n(9, 1'b1);  push_n(7, 1'b0);
        push_n(8, 1'b1);  push_n(8, 1'b0);
        push_n(16, 1'b0);
        push_n(16, 1'b1);
        measure_latency(75, "avg16");
        wait_idle("avg16");
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        checks++;
        if (g0 !== {2'd0, 12'd9}) begin
            failures++;
            $display("FAIL avg16_result: got ch=%0d res=%0d required ch=0 res=9", g0[13:12], g0[11:0]);
        end
    endtask

    task automatic test_overflow();
        int n;
        int t;
        logic [13:0] g0, g1;
        prep(4'b0001, 3'd0, 1'b1, 1'b0);
        push_dec(12'h001);
        push_dec(12'h002);
        push_dec(12'h004);
        do_start();
        n = 0;
        t = 0;
        while (n < 3 && t < 300) begin
            tick();
            t++;
            if (conv_finished) n++;
            if (n == 2 && enable) continuous = 1'b0;
        end
        wait_idle("ovf");
        checks++;
        if (n !== 3 || fin_cnt !== 3) begin
            failures++;
            $display("FAIL ovf_conversions: got %0d/%0d required 3", n, fin_cnt);
        end
        checks++;
        if (res_if.overflow !== 1'b1 || res_if.result_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got ovf=%b valid=%b required 1/1", res_if.overflow, res_if.result_valid);
        end
        checks++;
        if ({res_if.result_ch, res_if.result_data} !== {2'd0, 12'd1}) begin
            failures++;
            $display("FAIL ovf_head: got ch=%0d res=%0d required ch=0 res=1",
                     res_if.result_ch, res_if.result_data);
        end
        res_if.ovf_clear = 1'b1;
        tick();
        res_if.ovf_clear = 1'b0;
        checks++;
        if (res_if.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got ovf=%b required 0", res_if.overflow);
        end
        got_q.delete();
        res_if.result_ready = 1'b1;
        tick(); tick(); tick();
        res_if.result_ready = 1'b0;
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        g1 = (got_q.size() > 1) ? got_q[1] : 14'h3FFF;
        checks++;
        if (got_q.size() !== 2 || g0 !== {2'd0, 12'd1} || g1 !== {2'd0, 12'd2}) begin
            failures++;
            $display("FAIL ovf_drain: got n=%0d first=%0d second=%0d required 2 results 1 then 2",
                     got_q.size(), g0[11:0], g1[11:0]);
        end
        checks++;
        if (res_if.result_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_empty: got valid=%b required 0", res_if.result_valid);
        end
    endtask

    task automatic test_ignored_start();
        logic [13:0] g0;
        prep(4'b0000, 3'd0, 1'b0, 1'b1);
        do_start();
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || sample !== 1'b0 || fin_cnt !== 0) begin
            failures++;
            $display("FAIL zero_mask: got busy=%b sample=%b pulses=%0d required 0/0/0", busy, sample, fin_cnt);
        end
        ch_mask = 4'b0001;
        push_dec(12'h0F0);
        do_start();
        tick(); tick(); tick(); tick();
        ch_mask = 4'b0010;
        do_start();
        wait_idle("busy_start");
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        checks++;
        if (fin_cnt !== 1 || got_q.size() !== 1 || g0 !== {2'd0, 12'd191}) begin
            failures++;
            $display("FAIL busy_start: got pulses=%0d n=%0d ch=%0d res=%0d required 1/1 ch=0 res=191",
                     fin_cnt, got_q.size(), g0[13:12], g0[11:0]);
        end
    endtask

    task automatic test_reset_mid_conv();
        int t;
        logic [13:0] g0;
        prep(4'b0100, 3'd0, 1'b0, 1'b1);
        push_dec(12'hFFF);
        do_start();
        t = 0;
        while (!enable && t < 20) begin
            tick();
            t++;
        end
        repeat (5) tick();
        checks++;
        if (p_switch !== 12'hF80 || ch_sel !== 2'd2 || enable !== 1'b1) begin
            failures++;
            $display("FAIL step6_state: got p=%h ch=%0d en=%b required F80/2/1", p_switch, ch_sel, enable);
        end
        nrst = 1'b0;
        #1;
        test_reset();
        tick();
        nrst = 1'b1;
        prep(4'b0001, 3'd0, 1'b0, 1'b1);
        push_dec(12'hAAA);
        do_start();
        wait_idle("post_reset");
        g0 = (got_q.size() > 0) ? got_q[0] : 14'h3FFF;
        checks++;
        if (fin_cnt !== 1 || g0 !== {2'd0, 12'd1554}) begin
            failures++;
            $display("FAIL post_reset: got pulses=%0d ch=%0d res=%0d required 1 ch=0 res=1554",
                     fin_cnt, g0[13:12], g0[11:0]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fin_cnt = 0;
        nrst = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        ch_mask = 4'b0000;
        avg_mode = 3'd0;
        comparator_in = 1'b0;
        res_if.result_ready = 1'b0;
        res_if.ovf_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        nrst = 1'b1;
        tick();
        test_single();
        test_avg();
        test_avg_clamp();
        test_overflow();
        test_ignored_start();
        test_reset_mid_conv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
